// File: rtl/oled_mode_arbiter.sv
// -----------------------------------------------------------------------------
// oled_mode_arbiter
//
// Decides which of five pixel sources owns the OLED display. Mode switch
// requests are priority-encoded and must stay unchanged for STABLE_CYCLES
// clocks before they count. Ownership only changes on an OLED frame boundary.
// Between two owners, BLANK_FRAMES all-black frames are shown so that no frame
// ever mixes pixels from two sources.
//
// Ports
//   clock        in   1   100 MHz system clock, sole clock of the block
//   rst_n        in   1   synchronous active-low reset
//   mode_sw      in   5   mode requests ([4] group .. [0] find-the-white)
//   frame_begin  in   1   OLED frame-start level (asynchronous)
//   pix_bus      in  80   candidate pixels, source i at [16*i+15:16*i]
//   pixel_out    out 16   registered pixel to the OLED driver
//   grant        out  5   one-hot display owner, zero when none
//   busy         out  1   high while a handoff is pending or blanking
//   switch_count out  8   number of entries into ACTIVE, saturating at 255
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module oled_mode_arbiter #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int BLANK_FRAMES  = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [4:0]  mode_sw,
    input  logic        frame_begin,
    input  logic [79:0] pix_bus,
    output logic [15:0] pixel_out,
    output logic [4:0]  grant,
    output logic        busy,
    output logic [7:0]  switch_count
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int BLANK_W = $clog2(BLANK_FRAMES + 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST  = BLANK_W'(BLANK_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_BLANK  = 3'd4
    } state_t;

    // Highest set request bit wins; result is one-hot or zero.
    function automatic logic [4:0] encode_request(input logic [4:0] req);
        logic [4:0] onehot;
        onehot = 5'b00000;
        if (req[4])      onehot = 5'b10000;
        else if (req[3]) onehot = 5'b01000;
        else if (req[2]) onehot = 5'b00100;
        else if (req[1]) onehot = 5'b00010;
        else if (req[0]) onehot = 5'b00001;
        else             onehot = 5'b00000;
        return onehot;
    endfunction

    // One-hot mux of the pixel bus; a zero grant selects black.
    function automatic logic [15:0] select_pixel(input logic [4:0]  sel,
                                                 input logic [79:0] bus);
        logic [15:0] pix;
        pix = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            if (sel[i]) pix = pix | bus[16*i +: 16];
            else        pix = pix;
        end
        return pix;
    endfunction

    state_t              state_q,    state_d;
    logic [4:0]          grant_q,    grant_d;
    logic [4:0]          cand_q,     cand_d;
    logic [4:0]          stable_q,   stable_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [BLANK_W-1:0]  blank_q,    blank_d;
    logic [7:0]          count_q,    count_d;
    logic [15:0]         pixel_q,    pixel_d;
    logic [2:0]          sync_q,     sync_d;
    logic [4:0]          enc_s;
    logic                fb_pulse_s;
    logic                enter_active_s;

    // Synchronizer shift: [0],[1] resynchronize frame_begin, [2] is the edge-detect history.
    always_comb begin
        sync_d = {sync_q[1:0], frame_begin};
    end

    assign fb_pulse_s = sync_q[1] & ~sync_q[2];
    assign enc_s      = encode_request(mode_sw);

    // Request filter: any change restarts qualification from zero.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (enc_s != cand_q) begin
            cand_d = enc_s;
            cnt_d  = {CNT_W{1'b0}};
        end else if (cnt_q == STABLE_LAST) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Ownership FSM; in DRAIN the cancel check takes precedence over a frame boundary.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        blank_d        = blank_q;
        enter_active_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stable_q != 5'b00000) state_d = ST_WAIT;
                else                      state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (stable_q == 5'b00000) begin
                    state_d = ST_IDLE;
                end else if (fb_pulse_s) begin
                    grant_d        = stable_q;
                    state_d        = ST_ACTIVE;
                    enter_active_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (stable_q != grant_q) state_d = ST_DRAIN;
                else                     state_d = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (stable_q == grant_q) begin
                    state_d = ST_ACTIVE;
                end else if (fb_pulse_s) begin
                    grant_d = 5'b00000;
                    blank_d = {BLANK_W{1'b0}};
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_BLANK: begin
                if (fb_pulse_s) begin
                    if (blank_q == BLANK_LAST) begin
                        if (stable_q != 5'b00000) begin
                            grant_d        = stable_q;
                            state_d        = ST_ACTIVE;
                            enter_active_s = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        blank_d = blank_q + BLANK_W'(1);
                    end
                end else begin
                    state_d = ST_BLANK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 5'b00000;
            end
        endcase
    end

    // Saturating owner-switch counter and registered pixel mux.
    always_comb begin
        if (enter_active_s && (count_q != 8'hFF)) count_d = count_q + 8'd1;
        else                                      count_d = count_q;
        pixel_d = select_pixel(grant_q, pix_bus);
    end

    // State register; reset abandons any handoff and restarts qualification.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 5'b00000;
            cand_q   <= 5'b00000;
            stable_q <= 5'b00000;
            cnt_q    <= {CNT_W{1'b0}};
            blank_q  <= {BLANK_W{1'b0}};
            count_q  <= 8'd0;
            pixel_q  <= 16'h0000;
            sync_q   <= 3'b000;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            blank_q  <= blank_d;
            count_q  <= count_d;
            pixel_q  <= pixel_d;
            sync_q   <= sync_d;
        end
    end

    assign busy         = (state_q == ST_WAIT) || (state_q == ST_DRAIN) || (state_q == ST_BLANK);
    assign grant        = grant_q;
    assign pixel_out    = pixel_q;
    assign switch_count = count_q;

endmodule

// File: doc/oled_mode_arbiter.md
OLED_MODE_ARBITER -- requirements
Module: oled_mode_arbiter

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1_000_000, clock cycles a mode request must hold unchanged before acceptance (10 ms at 100 MHz); legal range >= 1.
REQ-002 SHALL have parameter BLANK_FRAMES, default 1, number of all-black frames inserted between owners; legal range >= 1.
REQ-003 SHALL have port clock  in  1  100 MHz system clock, sole clock of the block.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous to clock, active-low.
REQ-005 SHALL have port mode_sw  in  5  mode requests: [4] group task, [3] student C, [2] student D, [1] piano display, [0] find-the-white.
REQ-006 SHALL have port frame_begin  in  1  OLED frame start level from the 6.25 MHz OLED domain, asynchronous to clock.
REQ-007 SHALL have port pix_bus  in  80  candidate pixel data, source i at bits [16*i+15:16*i], same index as mode_sw.
REQ-008 SHALL have port pixel_out  out  16  pixel data driven to the OLED driver.
REQ-009 SHALL have port grant  out  5  one-hot current display owner; all-zero when no owner.
REQ-010 SHALL have port busy  out  1  high while a handoff is pending or blanking.
REQ-011 SHALL have port switch_count  out  8  number of entries into ACTIVE, saturating at 255.

Function
REQ-012 SHALL priority-encode mode_sw to a one-hot request: highest set index wins; all-zero if no bit set.
REQ-013 SHALL filter the request: candidate register plus counter; counter clears and candidate reloads whenever encoded request != candidate; stable_req <= candidate once the counter has seen STABLE_CYCLES consecutive matching cycles.
REQ-014 SHALL pass frame_begin through a 2-flop synchronizer and generate fb_pulse, a single-cycle pulse on its synchronized rising edge.
REQ-015 SHALL implement FSM states IDLE, WAIT, ACTIVE, DRAIN, BLANK.
REQ-016 IDLE: grant=0. Go to WAIT when stable_req != 0.
REQ-017 WAIT: grant=0. Go to IDLE if stable_req returns to 0. On fb_pulse with stable_req != 0, load grant <= stable_req and go to ACTIVE.
REQ-018 ACTIVE: hold grant. Go to DRAIN when stable_req != grant.
REQ-019 DRAIN: hold old grant until a frame boundary. Go to ACTIVE with no blank and no count increment if stable_req == grant again. Otherwise, on fb_pulse, clear grant, clear blank counter and go to BLANK.
REQ-020 BLANK: grant=0; each fb_pulse increments the blank counter. On the fb_pulse that completes BLANK_FRAMES frames, load grant <= stable_req and go to ACTIVE if stable_req != 0, else go to IDLE.
REQ-021 When a stable_req change and fb_pulse occur in the same DRAIN cycle, the cancel check (REQ-019) SHALL be evaluated first.
REQ-022 SHALL register pixel_out with 1-cycle latency: pix_bus slice selected by grant, or 16'h0000 when grant=0.
REQ-023 SHALL assert busy combinationally in WAIT, DRAIN and BLANK.
REQ-024 SHALL increment switch_count on every transition into ACTIVE from WAIT or BLANK, holding at 255.
REQ-025 SHALL keep grant one-hot or zero at all times; a grant change SHALL take effect only on an fb_pulse cycle.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, grant=0, pixel_out=0, busy=0, switch_count=0, candidate/stable_req=0, filter and blank counters=0, synchronizer flops=0.
REQ-027 Asserting reset mid-handoff (DRAIN/BLANK) SHALL abandon the handoff; after release the block SHALL re-qualify mode_sw from scratch through the filter.

Verification (bench uses STABLE_CYCLES=4, BLANK_FRAMES=1)
REQ-028 Stimulus: reset, then mode_sw=5'b00100, then fb_pulse. Required: grant stays 0 until 4 stable cycles plus the fb_pulse; then grant=5'b00100, switch_count=1; pixel_out equals pix_bus[47:32] one cycle later.
REQ-029 Stimulus: mode_sw=5'b10001. Required: grant=5'b10000 (priority).
REQ-030 Stimulus: ACTIVE on 5'b00001, mode_sw changes to 5'b01000, then 2 fb_pulses. Required: old pixels until the first pulse; pixel_out=0 and busy=1 for one frame; grant=5'b01000 after the second pulse; switch_count incremented by 1.
REQ-031 Stimulus: mode_sw glitches for 3 cycles (< STABLE_CYCLES) during ACTIVE. Required: no DRAIN, grant unchanged, busy=0.
REQ-032 Stimulus: DRAIN, then mode_sw returns to the original owner before fb_pulse. Required: back to ACTIVE, no blank frame, switch_count unchanged.
REQ-033 Stimulus: rst_n=0 for one cycle during BLANK. Required: all outputs zero on the next cycle; requalification takes 4 cycles plus an fb_pulse before a new grant.
